// File: rtl/hamming_distance_stream_if.sv
// Operand/result stream bundle for hamming_distance_stream.
// slave = the bit-difference engine, master = the source/sink around it.
interface hamming_distance_stream_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 16
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff_bits;
  logic [CNT_W-1:0] out_count;
  logic             out_match;
  logic [ACC_W-1:0] out_total;
  logic             out_ovf;
  logic             out_last;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_diff_bits, out_count, out_match, out_total, out_ovf,
           out_last
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_diff_bits, out_count, out_match, out_total, out_ovf,
           out_last
  );
endinterface

// File: rtl/hamming_distance_stream.sv
// Two-stage streaming XOR/popcount engine with a per-frame Hamming-distance total.
// Build option HD_SATURATE_EN: frame total clamps at 2^ACC_W-1 instead of wrapping.
module hamming_distance_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  hamming_distance_stream_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] TOTAL_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_diff_q;
  logic             s1_last_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_diff_q;
  logic [CNT_W-1:0] s2_count_q;
  logic [ACC_W-1:0] s2_total_q;
  logic             s2_ovf_q;
  logic             s2_match_q;
  logic             s2_last_q;
  logic             frame_start_q;

  logic             s2_ready, s2_load, in_ready, in_fire;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] total_next;
  logic             ovf_next;

  // Handshake: a stage loads when empty or when its occupant leaves this cycle.
  always_comb begin
    s2_ready   = !s2_valid_q || bus.out_ready;
    s2_load    = s1_valid_q && s2_ready;
    in_ready   = !s1_valid_q || s2_ready;
    in_fire    = bus.in_valid && in_ready;
    s1_valid_d = in_fire || (s1_valid_q && !s2_load);
    s2_valid_d = s2_load || (s2_valid_q && !bus.out_ready);
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(s1_diff_q[i]);
    end
  end

  // Accumulator state is the S2 total/ovf itself; it only moves on an S2 load.
  always_comb begin
    sum      = (frame_start_q ? '0 : {1'b0, s2_total_q}) + SUM_W'(count);
    ovf_next = (frame_start_q ? 1'b0 : s2_ovf_q) | sum[ACC_W];
`ifdef HD_SATURATE_EN
    total_next = sum[ACC_W] ? TOTAL_MAX : sum[ACC_W-1:0];
`else
    total_next = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_diff_q     <= '0;
      s1_last_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_diff_q     <= '0;
      s2_count_q    <= '0;
      s2_total_q    <= '0;
      s2_ovf_q      <= 1'b0;
      s2_match_q    <= 1'b0;
      s2_last_q     <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_diff_q <= bus.in_a ^ bus.in_b;
        s1_last_q <= bus.in_last;
      end
      if (s2_load) begin
        s2_diff_q     <= s1_diff_q;
        s2_count_q    <= count;
        s2_total_q    <= total_next;
        s2_ovf_q      <= ovf_next;
        s2_match_q    <= (count == '0);
        s2_last_q     <= s1_last_q;
        frame_start_q <= s1_last_q;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = s2_valid_q;
  assign bus.out_diff_bits = s2_diff_q;
  assign bus.out_count     = s2_count_q;
  assign bus.out_match     = s2_match_q;
  assign bus.out_total     = s2_total_q;
  assign bus.out_ovf       = s2_ovf_q;
  assign bus.out_last      = s2_last_q;
endmodule

// File: tb/tb_hamming_distance_stream.sv
// Directed plus random checks of hamming_distance_stream against a frame-sum reference model.
// Honours HD_SATURATE_EN the same way the design build does.
module tb_hamming_distance_stream;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ACC_W = 4;
  localparam int MAXT = (1 << ACC_W) - 1;
`ifdef HD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] diff;
    int               count;
    int               total;
    bit               ovf;
    bit               last;
    int               t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_distance_stream_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();
  hamming_distance_stream #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   pop_tot[$];
  bit   pop_ovf[$];
  int   cyc_n = 0;
  int   run_sum = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  logic [WIDTH-1:0] last_diff;
  int   last_count;
  bit   last_match, last_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check and update the model at negedge.
  task automatic cycle(input bit r, input bit v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit l, input bit rdy);
    exp_t e;
    bit   exp_ov;
    rst           = r;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_last   = l;
    bus.out_ready = rdy;
    @(negedge clk);
    if (r) begin
      q.delete();
      run_sum = 0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || rdy));
      exp_ov = (q.size() > 0) && (cyc_n >= q[0].t + 2);
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (bus.out_valid && q.size() > 0) begin
        e = q[0];
        chk("diff", 32'(bus.out_diff_bits), 32'(e.diff));
        chk("count", 32'(bus.out_count), e.count);
        chk("match", 32'(bus.out_match), 32'(e.count == 0));
        chk("total", 32'(bus.out_total), e.total);
        chk("ovf", 32'(bus.out_ovf), 32'(e.ovf));
        chk("last", 32'(bus.out_last), 32'(e.last));
        if (rdy) begin
          last_diff  = e.diff;
          last_count = e.count;
          last_match = bus.out_match;
          last_last  = bus.out_last;
          pop_tot.push_back(int'(bus.out_total));
          pop_ovf.push_back(bus.out_ovf);
          void'(q.pop_front());
          n_out++;
        end
      end
      if (v && bus.in_ready) begin
        e.diff  = a ^ b;
        e.count = $countones(a ^ b);
        run_sum += e.count;
        e.ovf   = run_sum > MAXT;
        e.total = SAT ? ((run_sum > MAXT) ? MAXT : run_sum) : (run_sum % (MAXT + 1));
        e.last  = l;
        e.t     = cyc_n;
        q.push_back(e);
        if (l) run_sum = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, rdy);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    bit rv, rl, pend;
    int base;

    // Reset state
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_total", 32'(bus.out_total), 0);
    chk("rst_diff", 32'(bus.out_diff_bits), 0);
    chk("rst_ovf", 32'(bus.out_ovf), 0);
    idle(2, 1'b1);

    // Single-word frame, 2-cycle latency
    cycle(1'b0, 1'b1, 8'hF0, 8'h0F, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("dir_diff", 32'(last_diff), 32'hFF);
    chk("dir_count", last_count, 8);
    chk("dir_total", pop_tot[$], 8);
    chk("dir_match", 32'(last_match), 0);
    chk("dir_last", 32'(last_last), 1);

    // Back-to-back frames
    pop_tot.delete();
    base = n_out;
    cycle(1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h07, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("b2b_n", n_out - base, 4);
    chk("b2b_t0", pop_tot[0], 1);
    chk("b2b_t1", pop_tot[1], 3);
    chk("b2b_t2", pop_tot[2], 6);
    chk("b2b_t3", pop_tot[3], 0);
    chk("b2b_match", 32'(last_match), 1);

    // Output stall for 5 cycles while the source keeps offering
    base = n_out;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(i + 1), 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("stall_drain", q.size(), 0);
    chk("stall_n", n_out - base, 3);

    // Overflow at ACC_W=4: three words of count 8
    pop_tot.delete();
    pop_ovf.delete();
    cycle(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("ovf_t0", pop_tot[0], 8);
    chk("ovf_t1", pop_tot[1], SAT ? 15 : 0);
    chk("ovf_t2", pop_tot[2], SAT ? 15 : 8);
    chk("ovf_f0", 32'(pop_ovf[0]), 0);
    chk("ovf_f1", 32'(pop_ovf[1]), 1);
    chk("ovf_f2", 32'(pop_ovf[2]), 1);

    // Reset mid-frame with both stages full
    cycle(1'b0, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("mrst_out_valid", 32'(bus.out_valid), 0);
    chk("mrst_in_ready", 32'(bus.in_ready), 1);
    pop_tot.delete();
    cycle(1'b0, 1'b1, 8'h3C, 8'h00, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("mrst_total", pop_tot[0], 4);

    // Random traffic with held payloads and occasional resets
    pend = 1'b0;
    rv = 1'b0; rl = 1'b0; ra = '0; rb = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend) begin
        rv = ($urandom_range(0, 3) != 0);
        ra = 8'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
        rl = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        pend = 1'b0;
      end else begin
        pend = rv && !bus.in_ready;
        // in_ready sampled here is pre-drive; recompute after the cycle instead
        cycle(1'b0, rv, ra, rb, rl, ($urandom_range(0, 2) != 0));
        pend = rv && (q.size() == 0 || q[$].t != cyc_n - 1);
      end
    end
    idle(4, 1'b1);
    chk("final_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
